// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with row synchroniser,
// whole-scan debounce, single-key hex encoding and a 4-digit shift register
// that feeds the 7-segment wrapper directly.
module keypad_scanner #(
  parameter int SCAN_DIV       = 99999,
  parameter int DEBOUNCE_SCANS = 20,
  parameter int DIV_WIDTH      = 17
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  ROW_IN,
  output logic [3:0]  COL_OUT,
  output logic        KEY_VALID,
  output logic [3:0]  KEY_CODE,
  output logic        KEY_HELD,
  output logic [15:0] DIGIT_OUT
);

  localparam int                   CNT_W     = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_WIDTH-1:0] L_DIV_TC  = DIV_WIDTH'(SCAN_DIV);
  localparam logic [DIV_WIDTH-1:0] L_DIV_ONE = DIV_WIDTH'(1);
  localparam logic [CNT_W-1:0]     L_DB      = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0]     L_CNT_ONE = CNT_W'(1);

  // Scan result classes; NONE and MULTI always carry code 0 so that the
  // "same as previous scan" comparison ignores stale code bits.
  localparam logic [1:0] RES_NONE  = 2'd0;
  localparam logic [1:0] RES_KEY   = 2'd1;
  localparam logic [1:0] RES_MULTI = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_REL_DB   = 2'd3
  } state_t;

  // Number of asserted (low) rows in one column sample.
  function automatic logic [2:0] f_count_low(input logic [3:0] low);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, low[i]};
    end
    return n;
  endfunction

  // Index of the lowest-numbered asserted row.
  function automatic logic [1:0] f_first_low(input logic [3:0] low);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (low[i]) begin
        idx = 2'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [3:0]           r_row_meta;
  logic [3:0]           r_row_sync;
  logic [DIV_WIDTH-1:0] r_presc;
  logic [1:0]           r_col;
  logic [3:0]           r_col_out;
  logic [1:0]           r_acc_cnt;
  logic [3:0]           r_acc_code;
  logic [1:0]           r_prev_type;
  logic [3:0]           r_prev_code;
  logic [CNT_W-1:0]     r_db_cnt;
  state_t               r_state;
  state_t               w_state_next;
  logic [3:0]           r_cand;
  logic                 r_key_valid;
  logic [3:0]           r_key_code;
  logic                 r_key_held;
  logic [15:0]          r_digits;

  logic                 w_tick;
  logic                 w_scan_done;
  logic [1:0]           w_col_next;
  logic [3:0]           w_col_low;
  logic [2:0]           w_col_cnt;
  logic [2:0]           w_tot_wide;
  logic [1:0]           w_tot_cnt;
  logic [3:0]           w_tot_code;
  logic [1:0]           w_res_type;
  logic [3:0]           w_res_code;
  logic                 w_same;
  logic [CNT_W-1:0]     w_cnt_next;
  logic                 w_db_done;
  logic                 w_res_is_cand;
  logic                 w_accept;
  logic                 w_release;
  logic                 w_load_cand;

  assign w_tick      = (r_presc == L_DIV_TC);
  assign w_scan_done = w_tick && (r_col == 2'd3);
  assign w_col_next  = r_col + 2'd1;

  // Two-flop synchroniser on the asynchronous row returns (idle rows read high).
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= ROW_IN;
      r_row_sync <= r_row_meta;
    end
  end

  // Column-period prescaler, wraps after SCAN_DIV.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + L_DIV_ONE;
    end
  end

  // Column index and registered one-cold strobe, advanced on each tick.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_col     <= 2'd0;
      r_col_out <= 4'b1110;
    end else if (w_tick) begin
      r_col     <= w_col_next;
      r_col_out <= ~(4'b0001 << w_col_next);
    end else begin
      r_col     <= r_col;
      r_col_out <= r_col_out;
    end
  end

  // Merge the current column sample into the running scan totals and classify.
  always_comb begin
    w_col_low  = ~r_row_sync;
    w_col_cnt  = f_count_low(w_col_low);
    w_tot_wide = {1'b0, r_acc_cnt} + w_col_cnt;
    if (w_tot_wide >= 3'd2) begin
      w_tot_cnt = 2'd2;
    end else begin
      w_tot_cnt = w_tot_wide[1:0];
    end
    if (r_acc_cnt == 2'd0) begin
      w_tot_code = {f_first_low(w_col_low), r_col};
    end else begin
      w_tot_code = r_acc_code;
    end
    case (w_tot_cnt)
      2'd0: begin
        w_res_type = RES_NONE;
        w_res_code = 4'h0;
      end
      2'd1: begin
        w_res_type = RES_KEY;
        w_res_code = w_tot_code;
      end
      default: begin
        w_res_type = RES_MULTI;
        w_res_code = 4'h0;
      end
    endcase
  end

  // Per-scan accumulators: loaded each tick, cleared once column 3 is folded in.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_acc_cnt  <= 2'd0;
      r_acc_code <= 4'h0;
    end else if (w_tick) begin
      if (r_col == 2'd3) begin
        r_acc_cnt  <= 2'd0;
        r_acc_code <= 4'h0;
      end else begin
        r_acc_cnt  <= w_tot_cnt;
        r_acc_code <= w_tot_code;
      end
    end else begin
      r_acc_cnt  <= r_acc_cnt;
      r_acc_code <= r_acc_code;
    end
  end

  // Saturating count of consecutive identical scan results.
  always_comb begin
    w_same = (w_res_type == r_prev_type) && (w_res_code == r_prev_code);
    if (w_same) begin
      if (r_db_cnt >= L_DB) begin
        w_cnt_next = L_DB;
      end else begin
        w_cnt_next = r_db_cnt + L_CNT_ONE;
      end
    end else begin
      w_cnt_next = L_CNT_ONE;
    end
    w_db_done     = (w_cnt_next >= L_DB);
    w_res_is_cand = (w_res_type == RES_KEY) && (w_res_code == r_cand);
  end

  // Previous scan result and debounce count, updated at end of scan.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_prev_type <= RES_NONE;
      r_prev_code <= 4'h0;
      r_db_cnt    <= '0;
    end else if (w_scan_done) begin
      r_prev_type <= w_res_type;
      r_prev_code <= w_res_code;
      r_db_cnt    <= w_cnt_next;
    end else begin
      r_prev_type <= r_prev_type;
      r_prev_code <= r_prev_code;
      r_db_cnt    <= r_db_cnt;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; only moves at end of scan.
  always_comb begin
    w_state_next = r_state;
    if (w_scan_done) begin
      case (r_state)
        ST_IDLE: begin
          if (w_res_type == RES_KEY) w_state_next = ST_PRESS_DB;
          else                       w_state_next = ST_IDLE;
        end
        ST_PRESS_DB: begin
          if (!w_res_is_cand)  w_state_next = ST_IDLE;
          else if (w_db_done)  w_state_next = ST_PRESSED;
          else                 w_state_next = ST_PRESS_DB;
        end
        ST_PRESSED: begin
          // Another key or a ghost pattern keeps the key held; only NONE releases.
          if (w_res_type == RES_NONE) w_state_next = ST_REL_DB;
          else                        w_state_next = ST_PRESSED;
        end
        ST_REL_DB: begin
          if (w_res_type != RES_NONE) w_state_next = ST_PRESSED;
          else if (w_db_done)         w_state_next = ST_IDLE;
          else                        w_state_next = ST_REL_DB;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end else begin
      w_state_next = r_state;
    end
  end

  // FSM output decode: candidate capture, accept and release strobes.
  always_comb begin
    w_accept    = 1'b0;
    w_release   = 1'b0;
    w_load_cand = 1'b0;
    if (w_scan_done) begin
      case (r_state)
        ST_IDLE:     w_load_cand = (w_res_type == RES_KEY);
        ST_PRESS_DB: w_accept    = w_res_is_cand && w_db_done;
        ST_REL_DB:   w_release   = (w_res_type == RES_NONE) && w_db_done;
        default:     w_accept    = 1'b0;
      endcase
    end else begin
      w_accept = 1'b0;
    end
  end

  // Candidate key captured when a debounce attempt starts.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cand <= 4'h0;
    end else if (w_load_cand) begin
      r_cand <= w_res_code;
    end else begin
      r_cand <= r_cand;
    end
  end

  // Registered key outputs; digit register shifts only on an accept.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_key_valid <= 1'b0;
      r_key_code  <= 4'h0;
      r_key_held  <= 1'b0;
      r_digits    <= 16'h0000;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) begin
        r_key_code <= r_cand;
        r_key_held <= 1'b1;
        r_digits   <= {r_digits[11:0], r_cand};
      end else if (w_release) begin
        r_key_held <= 1'b0;
      end else begin
        r_key_code <= r_key_code;
        r_key_held <= r_key_held;
        r_digits   <= r_digits;
      end
    end
  end

  assign COL_OUT   = r_col_out;
  assign KEY_VALID = r_key_valid;
  assign KEY_CODE  = r_key_code;
  assign KEY_HELD  = r_key_held;
  assign DIGIT_OUT = r_digits;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a fast scan (SCAN_DIV=3, DEBOUNCE_SCANS=2).
// A keypad model drives ROW_IN from a 16-bit pressed-key mask and COL_OUT.
module tb_keypad_scanner;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  ROW_IN;
  logic [3:0]  COL_OUT;
  logic        KEY_VALID;
  logic [3:0]  KEY_CODE;
  logic        KEY_HELD;
  logic [15:0] DIGIT_OUT;

  logic [15:0] keys;
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  int          long_pulses = 0;
  int          stray = 0;
  int          p0;
  int          n;
  logic        prev_valid = 1'b0;
  logic [15:0] prev_digit = 16'h0000;

  keypad_scanner #(
    .SCAN_DIV       (3),
    .DEBOUNCE_SCANS (2),
    .DIV_WIDTH      (17)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ROW_IN    (ROW_IN),
    .COL_OUT   (COL_OUT),
    .KEY_VALID (KEY_VALID),
    .KEY_CODE  (KEY_CODE),
    .KEY_HELD  (KEY_HELD),
    .DIGIT_OUT (DIGIT_OUT)
  );

  always #5 CLK = ~CLK;

  // Keypad: row r pulled low when a pressed key in row r sits on the strobed column.
  always_comb begin
    logic [3:0] rows;
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !COL_OUT[c]) rows[r] = 1'b0;
      end
    end
    ROW_IN = rows;
  end

  // Pulse counting and digit-change monitoring, sampled 1 time unit after each edge.
  always begin
    @(posedge CLK);
    #1;
    if (KEY_VALID) pulses++;
    if (KEY_VALID && prev_valid) long_pulses++;
    if (!RESET && (DIGIT_OUT !== prev_digit) && !KEY_VALID) stray++;
    prev_valid = KEY_VALID;
    prev_digit = DIGIT_OUT;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int cycles);
    repeat (cycles) @(negedge CLK);
  endtask

  initial begin
    keys  = 16'h0000;
    RESET = 1'b0;
    #2 RESET = 1'b1;
    wait_clk(3);
    RESET = 1'b0;

    // Reset state and column rotation every 4 clocks
    check("rst_col",   16'(COL_OUT),   16'h000E);
    check("rst_valid", 16'(KEY_VALID), 16'h0000);
    check("rst_code",  16'(KEY_CODE),  16'h0000);
    check("rst_held",  16'(KEY_HELD),  16'h0000);
    check("rst_digit", DIGIT_OUT,      16'h0000);
    wait_clk(4); check("col1", 16'(COL_OUT), 16'h000D);
    wait_clk(4); check("col2", 16'(COL_OUT), 16'h000B);
    wait_clk(4); check("col3", 16'(COL_OUT), 16'h0007);
    wait_clk(4); check("col0", 16'(COL_OUT), 16'h000E);

    // Single press row 2 col 1 -> code 9
    p0 = pulses;
    keys = 16'h0200;
    wait_clk(64);
    check("p9_pulses", 16'(pulses - p0), 16'h0001);
    check("p9_code",   16'(KEY_CODE),    16'h0009);
    check("p9_digit",  DIGIT_OUT,        16'h0009);
    check("p9_held",   16'(KEY_HELD),    16'h0001);
    wait_clk(32);
    check("p9_norepeat", 16'(pulses - p0), 16'h0001);
    keys = 16'h0000;
    wait_clk(6);
    check("p9_held_rel", 16'(KEY_HELD), 16'h0001);
    wait_clk(64);
    check("p9_released", 16'(KEY_HELD),    16'h0000);
    check("p9_pulses2",  16'(pulses - p0), 16'h0001);

    // Bounce on key 5: toggled every scan, then stable
    p0 = pulses;
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0020 : 16'h0000;
      wait_clk(16);
    end
    check("bounce_nopulse", 16'(pulses - p0), 16'h0000);
    keys = 16'h0020;
    wait_clk(64);
    check("bounce_pulse", 16'(pulses - p0), 16'h0001);
    check("bounce_code",  16'(KEY_CODE),    16'h0005);
    check("bounce_digit", DIGIT_OUT,        16'h0095);
    keys = 16'h0000;
    wait_clk(64);
    check("bounce_rel", 16'(KEY_HELD), 16'h0000);

    // Sequence 1,2,3,4 then 5
    p0 = pulses;
    for (int k = 1; k <= 4; k++) begin
      keys = 16'h0000;
      keys[k] = 1'b1;
      wait_clk(64);
      check("seq_code", 16'(KEY_CODE), 16'(k));
      keys = 16'h0000;
      wait_clk(64);
    end
    check("seq_digit4",  DIGIT_OUT,        16'h1234);
    check("seq_pulses4", 16'(pulses - p0), 16'h0004);
    keys = 16'h0020;
    wait_clk(64);
    keys = 16'h0000;
    wait_clk(64);
    check("seq_digit5", DIGIT_OUT,   16'h2345);
    check("seq_code5",  16'(KEY_CODE), 16'h0005);

    // MULTI: keys 0 and F together never accept
    p0 = pulses;
    keys = 16'h8001;
    wait_clk(64);
    check("multi_nopulse", 16'(pulses - p0), 16'h0000);
    check("multi_held",    16'(KEY_HELD),    16'h0000);
    keys = 16'h0000;
    wait_clk(64);
    check("multi_rel_nopulse", 16'(pulses - p0), 16'h0000);

    // Hold A, then add key 3: no new pulse, still held
    keys = 16'h0400;
    wait_clk(64);
    check("a_pulse", 16'(pulses - p0), 16'h0001);
    check("a_code",  16'(KEY_CODE),    16'h000A);
    check("a_held",  16'(KEY_HELD),    16'h0001);
    keys = 16'h0408;
    wait_clk(64);
    check("a_second_nopulse", 16'(pulses - p0), 16'h0001);
    check("a_second_held",    16'(KEY_HELD),    16'h0001);
    check("a_second_code",    16'(KEY_CODE),    16'h000A);
    keys = 16'h0000;
    wait_clk(64);
    check("a_rel_held",  16'(KEY_HELD),    16'h0000);
    check("a_rel_pulse", 16'(pulses - p0), 16'h0001);
    check("a_digit",     DIGIT_OUT,        16'h345A);

    // Reset while in PRESS_DB with key 7 (row 1 col 3)
    n = 0;
    while (COL_OUT === 4'b0111 && n < 32) begin
      @(negedge CLK);
      n++;
    end
    n = 0;
    while (COL_OUT !== 4'b0111 && n < 32) begin
      @(negedge CLK);
      n++;
    end
    check("align_col3", 16'(COL_OUT), 16'h0007);
    p0 = pulses;
    keys = 16'h0080;
    wait_clk(8);
    RESET = 1'b1;
    wait_clk(2);
    check("mid_rst_pulse", 16'(pulses - p0), 16'h0000);
    check("mid_rst_digit", DIGIT_OUT,        16'h0000);
    check("mid_rst_held",  16'(KEY_HELD),    16'h0000);
    check("mid_rst_col",   16'(COL_OUT),     16'h000E);
    RESET = 1'b0;
    wait_clk(64);
    check("post_rst_pulse", 16'(pulses - p0), 16'h0001);
    check("post_rst_code",  16'(KEY_CODE),    16'h0007);
    check("post_rst_digit", DIGIT_OUT,        16'h0007);
    check("post_rst_held",  16'(KEY_HELD),    16'h0001);
    keys = 16'h0000;
    wait_clk(64);
    check("post_rst_rel", 16'(KEY_HELD), 16'h0000);

    // Global properties over the whole run
    check("single_cycle_pulses", 16'(long_pulses), 16'h0000);
    check("digit_only_on_valid", 16'(stray),       16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad with one active-low column strobe at a time, the mirror of the multiplexed 7-segment drive. Synchronises and debounces the row returns and encodes the single pressed key to a 4-bit hex code. Shifts each accepted key into a 16-bit, 4-digit register. That register feeds the 7-segment wrapper's 16-bit digit input directly.

Parameters:
SCAN_DIV, 99999, prescaler terminal count; column advances every SCAN_DIV+1 clocks (1 kHz at 100 MHz)
DEBOUNCE_SCANS, 20, consecutive identical full scans (4 columns each) required to accept a press or a release
DIV_WIDTH, 17, prescaler width; must hold SCAN_DIV

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-high reset
ROW_IN  input  4  keypad rows, active low (pulled up externally); asynchronous to CLK
COL_OUT  output  4  column strobe, active low, exactly one bit low
KEY_VALID  output  1  one-CLK pulse when a debounced press is accepted
KEY_CODE  output  4  code of last accepted key, held until next accept
KEY_HELD  output  1  high from accept until debounced release
DIGIT_OUT  output  16  last four accepted codes; newest in [3:0]

Behaviour:
- Reset (async assert, sync release): prescaler 0, column index 0, COL_OUT=4'b1110, KEY_VALID=0, KEY_CODE=0, KEY_HELD=0, DIGIT_OUT=0, FSM=IDLE, scan accumulators and debounce counter cleared.
- ROW_IN passes through a 2-flop synchroniser before any use.
- Prescaler counts 0..SCAN_DIV and wraps; tick = one-cycle pulse when count==SCAN_DIV.
- On tick:
  - Sample the synchronised rows for the current column c (index 0..3).
  - Advance c modulo 4; COL_OUT = ~(1<<c), registered.
  - Rows are sampled at the end of a column period, so settling time is SCAN_DIV clocks.
- Per-scan accumulation over columns 0..3:
  - Count of low row bits and the (row,col) of a low bit.
  - Key at row r, column c encodes to {r[1:0], c[1:0]}. Example: row 2, column 1 gives 4'h9.
- Scan result, evaluated on the tick that samples column 3:
  - NONE: zero keys low.
  - KEY(code): exactly one key low.
  - MULTI: two or more keys low; handled as NONE for press purposes and does not release a held key (ghost protection).
- Debounce counter, saturating at DEBOUNCE_SCANS:
  - Increments when the scan result equals the previous scan result.
  - Otherwise reloads to 1.
- FSM, updated only at end of scan:
  - IDLE: result KEY(k) → PRESS_DB with candidate k.
  - PRESS_DB:
    - Result differs from candidate → IDLE.
    - Count reaches DEBOUNCE_SCANS with KEY(k) → PRESSED.
    - On that transition: KEY_VALID=1 for exactly one CLK, KEY_CODE<=k, DIGIT_OUT<={DIGIT_OUT[11:0],k}, KEY_HELD<=1.
  - PRESSED:
    - Result NONE → REL_DB.
    - KEY(other) or MULTI → stay in PRESSED; no new accept until a full release.
  - REL_DB:
    - Any non-NONE result → PRESSED.
    - DEBOUNCE_SCANS consecutive NONE → IDLE, KEY_HELD<=0.
- Latency: press stable from the start of a scan is accepted DEBOUNCE_SCANS·4·(SCAN_DIV+1) clocks later, ±1 scan depending on phase, plus 2 sync clocks.
- DIGIT_OUT wraps naturally: after the fifth key the oldest digit is dropped.
- Reset mid-debounce or mid-press: everything returns to reset values; KEY_VALID is never emitted for a press straddling reset.
- KEY_VALID and DIGIT_OUT update in the same cycle; DIGIT_OUT changes at no other time.

Test Plan:
- Reset check, with SCAN_DIV=3 and DEBOUNCE_SCANS=2: release reset → COL_OUT=1110, rotates 1101,1011,0111,1110 every 4 clocks; all outputs 0.
- Single press, row 2 col 1, held: exactly one KEY_VALID pulse; KEY_CODE=4'h9; DIGIT_OUT=16'h0009; KEY_HELD=1 until 2 clean NONE scans after release.
- Bounce: key 4'h5 toggled every scan for 6 scans, then stable → no pulse during bounce, one pulse after 2 stable scans.
- Sequence 1,2,3,4,5 with full release between each → DIGIT_OUT=16'h1234, then 16'h2345.
- Two keys pressed simultaneously (MULTI) → no KEY_VALID. While 4'hA is held, adding a second key → no new pulse and KEY_HELD stays 1.
- Assert RESET while in PRESS_DB → no pulse, DIGIT_OUT stays 0; key still held after reset → accepted normally after debounce.
